// File: rtl/exu_csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, op encodings,
// mstatus field positions, the default ECALL cause and the handshake FSM states.
package exu_csr_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    localparam logic [1:0] CSR_OPT_SYS = 2'b00;
    localparam logic [1:0] CSR_OPT_RW  = 2'b01;
    localparam logic [1:0] CSR_OPT_RS  = 2'b10;
    localparam logic [1:0] CSR_OPT_RC  = 2'b11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;

    localparam int ECALL_CAUSE_M = 11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } csr_state_e;

endpackage

// File: rtl/exu_csr_unit_if.sv
// Request/response bundle between the system-instruction decoder and the CSR unit.
interface exu_csr_unit_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [1:0]      i_opt;
    logic            i_sys;
    logic [11:0]     i_csrid;
    logic            i_csrsren;
    logic            i_csrdwen;
    logic [XLEN-1:0] i_wsrc;
    logic [XLEN-1:0] i_pc;
    logic            o_done;
    logic [XLEN-1:0] o_rdata;
    logic            o_illegal;
    logic            o_redirect;
    logic [XLEN-1:0] o_target;

    modport master (
        output i_valid, i_opt, i_sys, i_csrid, i_csrsren, i_csrdwen, i_wsrc, i_pc,
        input  o_ready, o_done, o_rdata, o_illegal, o_redirect, o_target
    );

    modport slave (
        input  i_valid, i_opt, i_sys, i_csrid, i_csrsren, i_csrdwen, i_wsrc, i_pc,
        output o_ready, o_done, o_rdata, o_illegal, o_redirect, o_target
    );
endinterface

// File: rtl/exu_csr_unit_csr_cycle_cnt.sv
// Free-running cycle counter with split low/high write ports; a write to either
// half replaces that half and freezes the other for that cycle.
module exu_csr_unit_csr_cycle_cnt #(
    parameter int CYC_W = 64,
    parameter int LO_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [LO_W-1:0]  wdata,
    output logic [CYC_W-1:0] count
);

    localparam logic [CYC_W-1:0] LO_MASK = CYC_W'({LO_W{1'b1}});

    logic [CYC_W-1:0] wide_w;

    assign wide_w = CYC_W'(wdata);

    // Software writes take priority over the increment and suppress any carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_lo) begin
            count <= (count & ~LO_MASK) | wide_w;
        end else if (wr_hi) begin
            count <= (count & LO_MASK) | ((wide_w << LO_W) & ~LO_MASK);
        end else begin
            count <= count + CYC_W'(1);
        end
    end

endmodule

// File: rtl/exu_csr_unit.sv
// Machine-mode CSR execution unit: CSR read/modify/write, ECALL/MRET trap state
// and the cycle counter, behind a one-in-flight valid/ready handshake.
module exu_csr_unit
    import exu_csr_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int CYC_W       = 64,
    parameter int ECALL_CAUSE = ECALL_CAUSE_M
) (
    input logic           i_clk,
    input logic           i_rst,
    exu_csr_unit_if.slave bus
);

    localparam bit HAS_MCYCLEH = (XLEN == 32) && (CYC_W > 32);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    csr_state_e state_q, state_d;

    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [XLEN-1:0] rdata_q, target_q;
    logic            illegal_q, redirect_q;

    logic [CYC_W-1:0] cyc_count;
    logic [XLEN-1:0]  cyc_lo, cyc_hi, old_val, new_val;
    logic             legal, accept, is_sys, do_ecall, do_mret, csr_we;

    assign accept   = bus.i_valid && (state_q == ST_IDLE);
    assign is_sys   = (bus.i_opt == CSR_OPT_SYS);
    assign do_ecall = accept && is_sys && !bus.i_sys;
    assign do_mret  = accept && is_sys && bus.i_sys;
    assign csr_we   = accept && !is_sys && bus.i_csrdwen && legal;
    assign cyc_lo   = XLEN'(cyc_count);
    assign cyc_hi   = XLEN'(cyc_count >> XLEN);

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.i_valid) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response fields are only visible during the RESP cycle and never under reset.
    always_comb begin
        bus.o_ready    = (state_q == ST_IDLE);
        bus.o_done     = (state_q == ST_RESP) && !i_rst;
        bus.o_rdata    = bus.o_done ? rdata_q : '0;
        bus.o_illegal  = bus.o_done && illegal_q;
        bus.o_redirect = bus.o_done && redirect_q;
        bus.o_target   = bus.o_done ? target_q : '0;
    end

    // mstatus reads back MPP as machine mode regardless of what was written.
    always_comb begin
        old_val = '0;
        legal   = 1'b1;
        case (bus.i_csrid)
            CSR_MSTATUS: begin
                old_val[MSTATUS_MIE]       = mie_q;
                old_val[MSTATUS_MPIE]      = mpie_q;
                old_val[MSTATUS_MPP_LO+:2] = 2'b11;
            end
            CSR_MTVEC:    old_val = mtvec_q;
            CSR_MSCRATCH: old_val = mscratch_q;
            CSR_MEPC:     old_val = mepc_q;
            CSR_MCAUSE:   old_val = mcause_q;
            CSR_MCYCLE:   old_val = cyc_lo;
            CSR_MCYCLEH: begin
                legal   = HAS_MCYCLEH;
                old_val = HAS_MCYCLEH ? cyc_hi : '0;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.i_opt)
            CSR_OPT_RS: new_val = old_val | bus.i_wsrc;
            CSR_OPT_RC: new_val = old_val & ~bus.i_wsrc;
            default:    new_val = bus.i_wsrc;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (do_ecall) begin
            mepc_q   <= bus.i_pc & ALIGN_MASK;
            mcause_q <= XLEN'(ECALL_CAUSE);
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (do_mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (csr_we) begin
            case (bus.i_csrid)
                CSR_MSTATUS: begin
                    mie_q  <= new_val[MSTATUS_MIE];
                    mpie_q <= new_val[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_q    <= new_val & ALIGN_MASK;
                CSR_MSCRATCH: mscratch_q <= new_val;
                CSR_MEPC:     mepc_q     <= new_val & ALIGN_MASK;
                CSR_MCAUSE:   mcause_q   <= new_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q    <= '0;
            illegal_q  <= 1'b0;
            redirect_q <= 1'b0;
            target_q   <= '0;
        end else if (accept) begin
            rdata_q    <= (!is_sys && legal && bus.i_csrsren) ? old_val : '0;
            illegal_q  <= !is_sys && !legal;
            redirect_q <= is_sys;
            target_q   <= !is_sys ? '0 : (bus.i_sys ? mepc_q : mtvec_q);
        end
    end

    exu_csr_unit_csr_cycle_cnt #(
        .CYC_W (CYC_W),
        .LO_W  (XLEN)
    ) u_cycle_cnt (
        .clk   (i_clk),
        .rst   (i_rst),
        .wr_lo (csr_we && (bus.i_csrid == CSR_MCYCLE)),
        .wr_hi (csr_we && (bus.i_csrid == CSR_MCYCLEH)),
        .wdata (new_val),
        .count (cyc_count)
    );

endmodule

// File: tb/tb_exu_csr_unit.sv
// Directed bench for exu_csr_unit: each request pushes its hand-computed response
// into a scoreboard queue that an independent monitor drains on every o_done.
module tb_exu_csr_unit;
    import exu_csr_unit_pkg::*;

    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
        logic        redirect;
        logic [31:0] target;
        int          acc_cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   issued = 0;
    int   seen   = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    exu_csr_unit_if #(.XLEN(XLEN)) bus ();

    exu_csr_unit #(
        .XLEN        (XLEN),
        .CYC_W       (64),
        .ECALL_CAUSE (11)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    function automatic void check_output(input string name, input logic [63:0] act,
                                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every o_done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.o_done !== 1'b0) begin
            seen++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got o_done=%b at cycle %0d, want 0",
                         bus.o_done, cyc);
            end else begin
                mon_e = sb.pop_front();
                check_output({mon_e.name, ".latency"}, 64'(cyc), 64'(mon_e.acc_cyc + 1));
                check_output({mon_e.name, ".rdata"}, 64'(bus.o_rdata), 64'(mon_e.rdata));
                check_output({mon_e.name, ".illegal"}, 64'(bus.o_illegal), 64'(mon_e.illegal));
                check_output({mon_e.name, ".redirect"}, 64'(bus.o_redirect), 64'(mon_e.redirect));
                check_output({mon_e.name, ".target"}, 64'(bus.o_target), 64'(mon_e.target));
            end
        end
    end

    task automatic apply_stimulus(input string name, input logic [1:0] opt, input logic sys,
                                  input logic [11:0] id, input logic ren, input logic wen,
                                  input logic [31:0] src, input logic [31:0] pc,
                                  input logic [31:0] exp_rdata, input logic exp_ill,
                                  input logic exp_redir, input logic [31:0] exp_tgt,
                                  input bit hold);
        int   budget;
        exp_t e;
        @(negedge clk);
        bus.i_valid   = 1'b1;
        bus.i_opt     = opt;
        bus.i_sys     = sys;
        bus.i_csrid   = id;
        bus.i_csrsren = ren;
        bus.i_csrdwen = wen;
        bus.i_wsrc    = src;
        bus.i_pc      = pc;
        budget = 0;
        while (bus.o_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (bus.o_ready !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL %s.ready_timeout: got o_ready=%b, want 1", name, bus.o_ready);
            bus.i_valid = 1'b0;
            return;
        end
        e.rdata    = exp_rdata;
        e.illegal  = exp_ill;
        e.redirect = exp_redir;
        e.target   = exp_tgt;
        e.acc_cyc  = cyc;
        e.name     = name;
        sb.push_back(e);
        issued++;
        @(posedge clk);
        @(negedge clk);
        if (hold) @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic csr_op(input string name, input logic [1:0] opt, input logic [11:0] id,
                          input logic ren, input logic wen, input logic [31:0] src,
                          input logic [31:0] exp_rdata, input logic exp_ill);
        apply_stimulus(name, opt, 1'b0, id, ren, wen, src, 32'h0, exp_rdata, exp_ill,
                       1'b0, 32'h0, 1'b0);
    endtask

    task automatic sys_op(input string name, input logic sys, input logic [31:0] pc,
                          input logic [31:0] exp_tgt);
        apply_stimulus(name, CSR_OPT_SYS, sys, 12'h7C0, 1'b1, 1'b1, 32'hFFFF_FFFF, pc,
                       32'h0, 1'b0, 1'b1, exp_tgt, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.i_valid   = 1'b0;
        bus.i_opt     = 2'b00;
        bus.i_sys     = 1'b0;
        bus.i_csrid   = 12'h0;
        bus.i_csrsren = 1'b0;
        bus.i_csrdwen = 1'b0;
        bus.i_wsrc    = 32'h0;
        bus.i_pc      = 32'h0;
        repeat (3) @(negedge clk);
        check_output("reset.ready", 64'(bus.o_ready), 64'h1);
        check_output("reset.done", 64'(bus.o_done), 64'h0);
        check_output("reset.rdata", 64'(bus.o_rdata), 64'h0);
        check_output("reset.illegal", 64'(bus.o_illegal), 64'h0);
        check_output("reset.redirect", 64'(bus.o_redirect), 64'h0);
        check_output("reset.target", 64'(bus.o_target), 64'h0);
        rst = 1'b0;

        // Basic reads/writes; the first request holds i_valid through RESP.
        apply_stimulus("rd_mstatus_hold", CSR_OPT_RS, 1'b0, CSR_MSTATUS, 1'b1, 1'b0, 32'h0,
                       32'h0, 32'h0000_1800, 1'b0, 1'b0, 32'h0, 1'b1);
        csr_op("rw_mscratch", CSR_OPT_RW, CSR_MSCRATCH, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
        csr_op("rc_mscratch", CSR_OPT_RC, CSR_MSCRATCH, 1'b1, 1'b1, 32'h0000_FFFF, 32'hDEAD_BEEF, 1'b0);
        csr_op("rd_mscratch", CSR_OPT_RS, CSR_MSCRATCH, 1'b1, 1'b0, 32'h0, 32'hDEAD_0000, 1'b0);

        // Trap entry through mtvec with WARL low bits, then MIE/MPIE round trip.
        csr_op("rw_mtvec", CSR_OPT_RW, CSR_MTVEC, 1'b1, 1'b1, 32'h8000_0103, 32'h0, 1'b0);
        csr_op("rd_mtvec", CSR_OPT_RS, CSR_MTVEC, 1'b1, 1'b0, 32'h0, 32'h8000_0100, 1'b0);
        sys_op("ecall1", 1'b0, 32'h8000_0040, 32'h8000_0100);
        csr_op("rd_mepc", CSR_OPT_RS, CSR_MEPC, 1'b1, 1'b0, 32'h0, 32'h8000_0040, 1'b0);
        csr_op("rd_mcause", CSR_OPT_RS, CSR_MCAUSE, 1'b1, 1'b0, 32'h0, 32'd11, 1'b0);
        csr_op("rd_mstatus_e1", CSR_OPT_RS, CSR_MSTATUS, 1'b1, 1'b0, 32'h0, 32'h0000_1800, 1'b0);
        csr_op("set_mie", CSR_OPT_RS, CSR_MSTATUS, 1'b1, 1'b1, 32'h0000_0008, 32'h0000_1800, 1'b0);
        sys_op("ecall2", 1'b0, 32'h8000_0040, 32'h8000_0100);
        csr_op("rd_mstatus_e2", CSR_OPT_RS, CSR_MSTATUS, 1'b1, 1'b0, 32'h0, 32'h0000_1880, 1'b0);
        sys_op("mret", 1'b1, 32'h1234_0000, 32'h8000_0040);
        csr_op("rd_mstatus_mret", CSR_OPT_RS, CSR_MSTATUS, 1'b1, 1'b0, 32'h0, 32'h0000_1888, 1'b0);

        // Writable-field masking, illegal address, mepc alignment.
        csr_op("rw_mstatus_all", CSR_OPT_RW, CSR_MSTATUS, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_1888, 1'b0);
        csr_op("rd_mstatus_all", CSR_OPT_RS, CSR_MSTATUS, 1'b1, 1'b0, 32'h0, 32'h0000_1888, 1'b0);
        csr_op("rc_mstatus", CSR_OPT_RC, CSR_MSTATUS, 1'b1, 1'b1, 32'h0000_0088, 32'h0000_1888, 1'b0);
        csr_op("rd_mstatus_clr", CSR_OPT_RS, CSR_MSTATUS, 1'b1, 1'b0, 32'h0, 32'h0000_1800, 1'b0);
        csr_op("illegal_7c0", CSR_OPT_RW, 12'h7C0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
        csr_op("rd_mscratch2", CSR_OPT_RS, CSR_MSCRATCH, 1'b1, 1'b0, 32'h0, 32'hDEAD_0000, 1'b0);
        csr_op("rd_mtvec2", CSR_OPT_RS, CSR_MTVEC, 1'b1, 1'b0, 32'h0, 32'h8000_0100, 1'b0);
        csr_op("rw_mepc", CSR_OPT_RW, CSR_MEPC, 1'b1, 1'b1, 32'h1234_5677, 32'h8000_0040, 1'b0);
        csr_op("rd_mepc2", CSR_OPT_RS, CSR_MEPC, 1'b1, 1'b0, 32'h0, 32'h1234_5674, 1'b0);

        // Back-to-back requests are two cycles apart: after the write in cycle a,
        // the count in cycle a+k is 0xFFFFFFFF + (k-1).
        csr_op("rw_mcycle", CSR_OPT_RW, CSR_MCYCLE, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0);
        csr_op("rd_mcycleh", CSR_OPT_RS, CSR_MCYCLEH, 1'b1, 1'b0, 32'h0, 32'h1, 1'b0);
        csr_op("rd_mcycle", CSR_OPT_RS, CSR_MCYCLE, 1'b1, 1'b0, 32'h0, 32'h2, 1'b0);
        csr_op("rw_mcycleh", CSR_OPT_RW, CSR_MCYCLEH, 1'b1, 1'b1, 32'h5, 32'h1, 1'b0);
        csr_op("rd_mcycleh2", CSR_OPT_RS, CSR_MCYCLEH, 1'b1, 1'b0, 32'h0, 32'h5, 1'b0);
        csr_op("rd_mcycle2", CSR_OPT_RS, CSR_MCYCLE, 1'b1, 1'b0, 32'h0, 32'h7, 1'b0);

        repeat (4) @(negedge clk);
        check_output("sb_drained", 64'(sb.size()), 64'h0);
        check_output("done_count", 64'(seen), 64'(issued));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exu_csr_unit.md
# exu_csr_unit

Machine-mode CSR execution unit for the NPC core: holds the architectural CSRs, performs CSRRW/CSRRS/CSRRC (register and immediate forms), ECALL and MRET, and runs the free-running cycle counter. It sits in EXU behind the system-instruction decoder and consumes its decoded fields: CSR id, read/write enables, op select and source operand. It is parametrised in data width and counter width, and uses a one-request-in-flight valid/ready handshake with a registered response.

## Interface
Parameters:
- XLEN, 32: datapath width; 32 or 64.
- CYC_W, 64: cycle counter width; at most 64, and at least XLEN.
- ECALL_CAUSE, 11: mcause value written by ECALL.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request this cycle.
- i_opt  in  2  00 system, 01 rw, 10 rs, 11 rc.
- i_sys  in  1  when i_opt=00: 0 ECALL, 1 MRET.
- i_csrid  in  12  CSR address.
- i_csrsren  in  1  read CSR old value to rd.
- i_csrdwen  in  1  write CSR.
- i_wsrc  in  XLEN  rs1 value or zero-extended uimm, already selected.
- i_pc  in  XLEN  PC of the instruction.
- o_done  out  1  one-cycle response pulse.
- o_rdata  out  XLEN  old CSR value; 0 if i_csrsren was 0.
- o_illegal  out  1  unknown CSR address; valid with o_done.
- o_redirect  out  1  ECALL/MRET taken; valid with o_done.
- o_target  out  XLEN  redirect PC; valid with o_redirect.

## Operation
- Implemented CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00.
- mcycleh 0xB80 exists only when XLEN=32 and CYC_W>32. It is the upper CYC_W-32 bits, zero-extended.
- Any other address is illegal.
- New value by op:
  - rw: src.
  - rs: old | src.
  - rc: old & ~src.
- Write happens only when i_csrdwen=1 and the address is legal.
- Illegal access: no state change; o_illegal=1; o_rdata=0.
- mtvec bits[1:0] and mepc bits[1:0] are WARL: they are written as 0.
- mstatus: only bits MIE[3], MPIE[7] and MPP[12:11] are writable. MPP reads as 2'b11 always. All other bits read 0.
- ECALL:
  - mepc <= i_pc; mcause <= ECALL_CAUSE.
  - MPIE <= MIE; MIE <= 0.
  - o_target = {mtvec[XLEN-1:2], 2'b00}.
- MRET:
  - MIE <= MPIE; MPIE <= 1.
  - o_target = mepc.
- For both ECALL and MRET, i_csrid, i_csrsren and i_csrdwen are ignored.
- mcycle increments by 1 every cycle out of reset and wraps at 2^CYC_W to 0.
- A CSR write to mcycle or mcycleh in the same cycle as the increment wins: the written half takes the written value, and the other half keeps its old value with no increment carry.

## Timing
- Two-state FSM:
  - IDLE: o_ready=1. On i_valid go to RESP.
  - RESP: o_ready=0. Always return to IDLE next cycle.
- A request is accepted on cycle N (i_valid & o_ready). CSR and trap state updates at the end of cycle N.
- Response is registered: o_done=1 for exactly cycle N+1, with o_rdata, o_illegal, o_redirect and o_target.
- o_rdata is the pre-write value sampled in cycle N. For mcycle this is the count before that edge's increment/write.
- Throughput: one request per 2 cycles. i_valid during RESP is ignored; the requester holds it.
- Outside o_done, the response outputs are 0.
- Reset values:
  - All outputs 0, except o_ready=1 (state IDLE).
  - mstatus = 0x1800; all other CSRs and mcycle = 0.
- Reset asserted in RESP: the FSM goes to IDLE and o_done is not asserted. A write accepted in the previous cycle has already committed; reset then overwrites it.

## Structure
- Shared package / defines.vh: CSR address constants, op encodings (CSR_OPT_*), mstatus bit positions, and the ECALL cause.
- One natural sub-module, csr_cycle_cnt. It holds the CYC_W counter, the split-write ports for the low and high halves, and the increment-vs-write priority.

## Test plan
- Reset, then read mstatus (opt=10, src=0, wen=0) -> o_done at N+1, o_rdata=0x1800, nothing written.
- CSRRW mscratch with src=0xDEADBEEF, then CSRRC with src=0x0000FFFF -> second o_rdata=0xDEADBEEF; a third read returns 0xDEAD0000.
- Write mtvec=0x80000103, then ECALL at pc=0x80000040 -> o_redirect=1, o_target=0x80000100, mepc=0x80000040, mcause=11, MIE cleared.
- Set MIE=1, ECALL, then MRET -> o_target=0x80000040; mstatus reads 0x1888 (MIE=1, MPIE=1).
- Read of address 0x7C0 with wen=1 -> o_illegal=1, o_rdata=0, no CSR changes.
- Write mcycle=0xFFFFFFFF (XLEN=32), let it run 2 cycles, then read mcycleh -> 1. Also hold i_valid during RESP and check that only one o_done occurs per accepted request.
